// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte master: one 8-bit full-duplex exchange per accepted start, own chip select.
// Latency: spi_done pulses 17*CLK_DIV cycles after the accepting edge; 17*CLK_DIV+2 cycles start-to-start.
// Backpressure: start is sampled only in IDLE and ignored while busy. SPI_LSB_FIRST_EN selects LSB-first bit order.
module spi_byte_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs,
    output logic       spi_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_q, cs_d;
    logic        done_q, done_d;

    logic        tx_first_bit;
    logic [7:0]  tx_next;
    logic        mosi_next;
    logic [7:0]  rx_next;
    logic        half_end;

    // TX register rotates so the bit after the one on mosi is always at a fixed position.
`ifdef SPI_LSB_FIRST_EN
    assign tx_first_bit = data_in[0];
    assign tx_next      = {tx_q[0], tx_q[7:1]};
    assign mosi_next    = tx_q[1];
    assign rx_next      = {miso, rx_q[7:1]};
`else
    assign tx_first_bit = data_in[7];
    assign tx_next      = {tx_q[6:0], tx_q[7]};
    assign mosi_next    = tx_q[6];
    assign rx_next      = {rx_q[6:0], miso};
`endif

    assign half_end = (cnt_q == DIV_M1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                cnt_d = 16'd0;
                bit_d = 3'd0;
                if (start) begin
                    tx_d    = data_in;
                    mosi_d  = tx_first_bit;
                    cs_d    = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_end) begin
                    cnt_d   = 16'd0;
                    sck_d   = 1'b1;
                    rx_d    = rx_next;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_d = 16'd0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        // After the last falling edge mosi keeps the final bit.
                        if (bit_q == 3'd7) begin
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = tx_next;
                            mosi_d = mosi_next;
                        end
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = rx_next;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (half_end) begin
                    cnt_d      = 16'd0;
                    cs_d       = 1'b1;
                    data_out_d = rx_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            data_out_q <= 8'h00;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;
    assign spi_done = done_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: two instances (CLK_DIV=4 and CLK_DIV=1), each with a behavioural mode-0 slave.
module tb_spi_byte_master;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] sck;
    logic [1:0] mosi;
    logic [1:0] miso;
    logic [1:0] cs;
    logic [1:0] done;
    logic [7:0] data_in  [2];
    logic [7:0] data_out [2];

    always #5 clk = ~clk;

    spi_byte_master #(.CLK_DIV(D0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .data_in(data_in[0]), .data_out(data_out[0]),
        .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]), .cs(cs[0]), .spi_done(done[0])
    );

    spi_byte_master #(.CLK_DIV(D1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .data_in(data_in[1]), .data_out(data_out[1]),
        .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]), .cs(cs[1]), .spi_done(done[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         rises      [2] = '{0, 0};
    int         sck_hi     [2] = '{0, 0};
    logic [7:0] mosi_word  [2] = '{8'h00, 8'h00};
    logic [7:0] slave_byte [2] = '{8'h00, 8'h00};
    logic [1:0] sck_prev = 2'b00;
    logic [1:0] cs_prev  = 2'b11;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    // Byte as it appears on the wire: bit 7 of the result is the first bit sent.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
        r = b;
`endif
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave + line monitor: present the next slave bit ahead of every sck rise, record mosi at each rise.
    always @(negedge clk) begin
        logic [7:0] w;
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (cs_prev[d] && !cs[d]) begin
                rises[d]     = 0;
                sck_hi[d]    = 0;
                mosi_word[d] = 8'h00;
            end
            if (sck[d] && !sck_prev[d]) begin
                mosi_word[d] = {mosi_word[d][6:0], mosi[d]};
                rises[d]     = rises[d] + 1;
            end
            if (sck[d]) sck_hi[d] = sck_hi[d] + 1;
            w   = wire_order(slave_byte[d]);
            idx = (rises[d] < 8) ? 7 - rises[d] : 0;
            miso[d]     = (!cs[d] && rises[d] < 8) ? w[idx] : 1'b0;
            sck_prev[d] = sck[d];
            cs_prev[d]  = cs[d];
        end
    end

    task automatic wait_accept(input int d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk); #1;
            ok = !cs[d];
        end
    endtask

    task automatic wait_done(input int d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 17 * div_of(d) + 30 && !ok; t++) begin
            @(negedge clk); #1;
            ok = done[d];
        end
    endtask

    task automatic xfer(input int d, input logic [7:0] din, input logic [7:0] sb, input bit poke);
        bit ok;
        int k;
        int dl;
        dl = div_of(d);
        slave_byte[d] = sb;
        data_in[d]    = din;
        start[d]      = 1'b1;
        wait_accept(d, ok);
        check("accept", 32'(ok), 32'd1);
        start[d] = 1'b0;
        if (!ok) return;
        k = cyc;
        data_in[d] = ~din;
        if (poke) begin
            repeat (5 * dl) @(negedge clk);
            #1;
            start[d]   = 1'b1;
            data_in[d] = 8'hFF;
            @(negedge clk); #1;
            start[d] = 1'b0;
        end
        wait_done(d, ok);
        check("done_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("done_latency", 32'(cyc - k), 32'(17 * dl));
        check("data_out", 32'(data_out[d]), 32'(sb));
        check("mosi_bits", 32'(mosi_word[d]), 32'(wire_order(din)));
        check("sck_pulses", 32'(rises[d]), 32'd8);
        check("sck_high_cycles", 32'(sck_hi[d]), 32'(8 * dl));
        check("cs_high_at_done", 32'(cs[d]), 32'd1);
        @(negedge clk); #1;
        check("done_one_cycle", 32'(done[d]), 32'd0);
    endtask

    initial begin
        bit ok;
        int k1, k2, c1, c2, gap, lows;

        rst        = 1'b0;
        start      = 2'b00;
        data_in[0] = 8'h00;
        data_in[1] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_cs", 32'(cs[d]), 32'd1);
            check("rst_sck", 32'(sck[d]), 32'd0);
            check("rst_mosi", 32'(mosi[d]), 32'd0);
            check("rst_data_out", 32'(data_out[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
        end
        rst = 1'b1;
        lows = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (!cs[0] || !cs[1] || sck != 2'b00 || done != 2'b00) lows++;
        end
        check("idle_no_activity", 32'(lows), 32'd0);

        xfer(0, 8'hA5, 8'h3C, 1'b0);
        xfer(1, 8'h01, 8'h01, 1'b0);

        // Busy protection: a start pulse mid-transfer must not launch a second exchange.
        xfer(0, 8'h0F, 8'h96, 1'b1);
        lows = 0;
        repeat (12) begin
            @(negedge clk); #1;
            if (!cs[0] || done[0]) lows++;
        end
        check("busy_no_retrigger", 32'(lows), 32'd0);

        // Back-to-back with start held high.
        slave_byte[0] = 8'h5A;
        data_in[0]    = 8'h26;
        start[0]      = 1'b1;
        wait_accept(0, ok);
        check("b2b_accept1", 32'(ok), 32'd1);
        k1 = cyc;
        data_in[0] = 8'h93;
        wait_done(0, ok);
        check("b2b_done1", 32'(ok), 32'd1);
        c1 = cyc;
        check("b2b_data1", 32'(data_out[0]), 32'h5A);
        check("b2b_mosi1", 32'(mosi_word[0]), 32'(wire_order(8'h26)));
        slave_byte[0] = 8'hC3;
        gap = 1;
        ok  = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk); #1;
            if (cs[0]) gap++;
            else ok = 1'b1;
        end
        check("b2b_accept2", 32'(ok), 32'd1);
        k2 = cyc;
        start[0] = 1'b0;
        check("b2b_cs_gap", 32'(gap >= 2), 32'd1);
        check("b2b_start_period", 32'(k2 - k1), 32'(17 * D0 + 2));
        wait_done(0, ok);
        check("b2b_done2", 32'(ok), 32'd1);
        c2 = cyc;
        check("b2b_done_period", 32'(c2 - c1), 32'd70);
        check("b2b_data2", 32'(data_out[0]), 32'hC3);
        check("b2b_mosi2", 32'(mosi_word[0]), 32'(wire_order(8'h93)));
        repeat (3) @(negedge clk);
        #1;

        // Asynchronous reset after three bits aborts the exchange.
        slave_byte[0] = 8'h00;
        data_in[0]    = 8'hAA;
        start[0]      = 1'b1;
        wait_accept(0, ok);
        start[0] = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk); #1;
            ok = (rises[0] >= 3);
        end
        check("abort_reached_bit3", 32'(ok), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_cs", 32'(cs[0]), 32'd1);
        check("abort_sck", 32'(sck[0]), 32'd0);
        check("abort_data_out", 32'(data_out[0]), 32'd0);
        lows = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done[0]) lows++;
        end
        rst = 1'b1;
        repeat (80) begin
            @(negedge clk); #1;
            if (done[0] || !cs[0]) lows++;
        end
        check("abort_no_done", 32'(lows), 32'd0);
        xfer(0, 8'h80, 8'hFF, 1'b0);

        for (int i = 0; i < 8; i++) begin
            xfer(i % 2, 8'($urandom), 8'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
